// File: rtl/sym_fir_param_if.sv
// sym_fir_param_if: sample stream, coefficient load port and filtered output
// of the symmetric FIR. The master drives samples and coefficients. The slave
// (the filter) returns out_valid / y_out.
interface sym_fir_param_if #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int TAPS   = 7,
  parameter int OUT_W  = 10
);
  localparam int NC = (TAPS + 1) / 2;
  localparam int AW = (NC > 1) ? $clog2(NC) : 1;

  logic                     in_valid;
  logic signed [DATA_W-1:0] x_in;
  logic                     coef_we;
  logic [AW-1:0]            coef_addr;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_commit;
  logic                     out_valid;
  logic signed [OUT_W-1:0]  y_out;

  modport master (
    output in_valid, x_in, coef_we, coef_addr, coef_data, coef_commit,
    input  out_valid, y_out
  );

  modport slave (
    input  in_valid, x_in, coef_we, coef_addr, coef_data, coef_commit,
    output out_valid, y_out
  );
endinterface

// File: rtl/sym_fir_param.sv
// sym_fir_param: pipelined linear-phase FIR with an odd tap count.
// Mirrored taps are pre-added, multiplied by a double-buffered coefficient
// bank, summed at full precision, then scaled down by SHIFT.
// The optional macro SYM_FIR_ROUND_SAT_EN turns on round-half-up and
// saturation in the output stage. Without it, the output stage uses floor
// truncation with wrap.
module sym_fir_param #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 16,
  parameter int TAPS   = 7,
  parameter int OUT_W  = 10,
  parameter int SHIFT  = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  sym_fir_param_if.slave bus
);
  localparam int NC    = (TAPS + 1) / 2;
  localparam int P_W   = DATA_W + 1;
  localparam int PR_W  = P_W + COEF_W;
  localparam int ACC_W = PR_W + $clog2(NC);

  if (((TAPS % 2) == 0) || (TAPS < 3)) begin : g_taps_check
    $error("sym_fir_param: TAPS must be odd and >= 3");
  end

`ifdef SYM_FIR_ROUND_SAT_EN
  localparam logic signed [ACC_W:0] HALF  = ((ACC_W+1)'(1) << SHIFT) >> 1;
  localparam logic signed [ACC_W:0] Y_MAX = (ACC_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] Y_MIN = -Y_MAX - (ACC_W+1)'(1);
`endif

  logic signed [DATA_W-1:0] tap_q     [TAPS];
  logic signed [COEF_W-1:0] shadow_q  [NC];
  logic signed [COEF_W-1:0] act_q     [NC];
  logic signed [P_W-1:0]    pre_d     [NC];
  logic signed [P_W-1:0]    pre_p1_q  [NC];
  logic signed [PR_W-1:0]   prod_d    [NC];
  logic signed [PR_W-1:0]   prod_p2_q [NC];
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [OUT_W-1:0]  y_p3_q;
  logic                     vld_p0_q, vld_p1_q, vld_p2_q, vld_p3_q;

  // Scale the accumulator down to the output width.
  function automatic logic signed [OUT_W-1:0] scale_out(input logic signed [ACC_W-1:0] acc);
`ifdef SYM_FIR_ROUND_SAT_EN
    logic signed [ACC_W:0] rsh;
    rsh = ((ACC_W+1)'(acc) + HALF) >>> SHIFT;
    if (rsh > Y_MAX)      return OUT_W'(Y_MAX);
    else if (rsh < Y_MIN) return OUT_W'(Y_MIN);
    else                  return OUT_W'(rsh);
`else
    return OUT_W'(acc >>> SHIFT);
`endif
  endfunction

  // Delay line advances only on accepted samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < TAPS; i++) tap_q[i] <= '0;
    end else if (bus.in_valid) begin
      tap_q[0] <= bus.x_in;
      for (int i = 1; i < TAPS; i++) tap_q[i] <= tap_q[i-1];
    end
  end

  // Shadow bank takes writes; commit copies the pre-write shadow into active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) begin
        shadow_q[i] <= '0;
        act_q[i]    <= '0;
      end
    end else begin
      if (bus.coef_we && (int'(bus.coef_addr) < NC))
        shadow_q[bus.coef_addr] <= bus.coef_data;
      if (bus.coef_commit)
        for (int i = 0; i < NC; i++) act_q[i] <= shadow_q[i];
    end
  end

  // Datapath: pre-add of mirrored taps, per-pair products and accumulator sum.
  always_comb begin
    for (int i = 0; i < NC; i++) begin
      pre_d[i]  = '0;
      prod_d[i] = '0;
    end
    acc_d = '0;
    // p0 -> p1: pre-add mirrored taps; the centre tap has no partner
    for (int i = 0; i < NC - 1; i++)
      pre_d[i] = P_W'(tap_q[i]) + P_W'(tap_q[TAPS-1-i]);
    pre_d[NC-1] = P_W'(tap_q[NC-1]);
    // p1 -> p2: every product of one sample uses the same active bank
    for (int i = 0; i < NC; i++)
      prod_d[i] = PR_W'(pre_p1_q[i]) * PR_W'(act_q[i]);
    // p2 -> p3: full-precision sum, cannot overflow ACC_W
    for (int i = 0; i < NC; i++)
      acc_d = acc_d + ACC_W'(prod_p2_q[i]);
  end

  // Pipeline registers with the valid bit riding alongside; y holds in gaps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      y_p3_q   <= '0;
      for (int i = 0; i < NC; i++) begin
        pre_p1_q[i]  <= '0;
        prod_p2_q[i] <= '0;
      end
    end else begin
      vld_p0_q <= bus.in_valid;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
      vld_p3_q <= vld_p2_q;
      for (int i = 0; i < NC; i++) begin
        pre_p1_q[i]  <= pre_d[i];
        prod_p2_q[i] <= prod_d[i];
      end
      if (vld_p2_q) y_p3_q <= scale_out(acc_d);
    end
  end

  assign bus.out_valid = vld_p3_q;
  assign bus.y_out     = y_p3_q;
endmodule

// File: tb/tb_sym_fir_param.sv
// Directed bench for sym_fir_param: impulse response, valid gaps,
// wrap/saturation, coefficient commit timing, mid-stream reset, and an
// out-of-range coefficient address on a 5-tap instance.
module tb_sym_fir_param;
  localparam int DATA_W = 8;
  localparam int COEF_W = 16;
  localparam int TAPS   = 7;
  localparam int OUT_W  = 10;
  localparam int SHIFT  = 14;

`ifdef SYM_FIR_ROUND_SAT_EN
  localparam int E1 = -7, E3 = 142, SAT_P = 511, SAT_N = -512, E_CM = 20;
`else
  localparam int E1 = -8, E3 = 141, SAT_P = -271, SAT_N = 256, E_CM = 19;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sym_fir_param_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();
  sym_fir_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  sym_fir_param_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(5), .OUT_W(OUT_W)) bus5 ();
  sym_fir_param #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(5), .OUT_W(OUT_W), .SHIFT(SHIFT))
    dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  typedef struct {
    logic vld;
    int   x;
    logic exp_ov;
    int   exp_y;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input int x, input logic ov, input int y);
    vec_t r;
    r.vld = v; r.x = x; r.exp_ov = ov; r.exp_y = y;
    tbl.push_back(r);
  endtask

  // Row i drives the inputs sampled at edge i and checks the outputs after it.
  task automatic run_tbl(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      bus.in_valid = tbl[i].vld;
      bus.x_in     = DATA_W'(tbl[i].x);
      tick();
      chk($sformatf("%s[%0d].out_valid", name, i), int'(bus.out_valid), int'(tbl[i].exp_ov));
      chk($sformatf("%s[%0d].y_out", name, i), int'(bus.y_out), tbl[i].exp_y);
    end
    bus.in_valid = 1'b0;
    tbl.delete();
  endtask

  task automatic load4(input int c0, input int c1, input int c2, input int c3);
    int c[4];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int i = 0; i < 4; i++) begin
      bus.coef_we   = 1'b1;
      bus.coef_addr = 2'(i);
      bus.coef_data = COEF_W'(c[i]);
      tick();
    end
    bus.coef_we     = 1'b0;
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    tick();
    tick();
  endtask

  task automatic stream(input int x, input int n);
    bus.in_valid = 1'b1;
    bus.x_in     = DATA_W'(x);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic add_impulse(input int a0, input int a1, input int a2, input int a3);
    add(1, 127, 0, 0); add(1, 0, 0, 0); add(1, 0, 0, 0);
    add(1, 0, 1, a0); add(1, 0, 1, a1); add(1, 0, 1, a2); add(1, 0, 1, a3);
    add(1, 0, 1, a2); add(1, 0, 1, a1); add(1, 0, 1, a0);
    add(1, 0, 1, 0);  add(1, 0, 1, 0);
  endtask

  initial begin
    int gap_y[18];
    int gap_ov[18];
    gap_y  = '{0, 0, 0, -12, -12, E1, E1, 75, 75, E3, E3, 75, 75, E1, E1, -12, -12, 0};
    gap_ov = '{1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 1};

    bus.in_valid = 0; bus.x_in = '0; bus.coef_we = 0; bus.coef_addr = '0;
    bus.coef_data = '0; bus.coef_commit = 0;
    bus5.in_valid = 0; bus5.x_in = '0; bus5.coef_we = 0; bus5.coef_addr = '0;
    bus5.coef_data = '0; bus5.coef_commit = 0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset.out_valid", int'(bus.out_valid), 0);
    chk("reset.y_out", int'(bus.y_out), 0);
    rst_n = 1'b1;
    tick();

    // Impulse response
    load4(-1495, -942, 9687, 18269);
    add_impulse(-12, E1, 75, E3);
    run_tbl("impulse");

    // Alternating in_valid: same values, gaps hold y_out
    for (int i = 0; i < 18; i++)
      add((i % 2) == 0, ((i % 2) == 0) ? ((i == 0) ? 127 : 0) : 55,
          gap_ov[i] != 0, gap_y[i]);
    run_tbl("gaps");

    // Full-scale coefficients: wrap or saturate
    load4(32767, 32767, 32767, 32767);
    stream(127, 12);
    chk("fullscale_pos.out_valid", int'(bus.out_valid), 1);
    chk("fullscale_pos.y_out", int'(bus.y_out), SAT_P);
    stream(-128, 12);
    chk("fullscale_neg.out_valid", int'(bus.out_valid), 1);
    chk("fullscale_neg.y_out", int'(bus.y_out), SAT_N);
    bus.in_valid = 1'b0;

    // Commit timing with a centre-only filter
    load4(0, 0, 0, 16384);
    stream(10, 12);
    chk("commit.base", int'(bus.y_out), 10);
    bus.coef_we = 1'b1; bus.coef_addr = 2'd3; bus.coef_data = 16'sd32767;
    tick();
    bus.coef_we = 1'b0;
    chk("commit.shadow_only0", int'(bus.y_out), 10);
    for (int i = 1; i < 5; i++) begin
      tick();
      chk($sformatf("commit.shadow_only%0d", i), int'(bus.y_out), 10);
    end
    // commit and a same-cycle write: active gets 32767, shadow gets 8192
    bus.coef_commit = 1'b1;
    bus.coef_we = 1'b1; bus.coef_addr = 2'd3; bus.coef_data = 16'sd8192;
    tick();
    bus.coef_commit = 1'b0; bus.coef_we = 1'b0;
    chk("commit.edge0", int'(bus.y_out), 10);
    tick();
    chk("commit.edge1", int'(bus.y_out), 10);
    tick();
    chk("commit.edge2", int'(bus.y_out), E_CM);
    tick();
    chk("commit.edge3", int'(bus.y_out), E_CM);
    bus.coef_commit = 1'b1;
    tick();
    bus.coef_commit = 1'b0;
    chk("recommit.edge0", int'(bus.y_out), E_CM);
    tick();
    chk("recommit.edge1", int'(bus.y_out), E_CM);
    tick();
    chk("recommit.edge2", int'(bus.y_out), 5);

    // Reset with samples in flight
    rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", int'(bus.out_valid), 0);
    chk("midreset.y_out", int'(bus.y_out), 0);
    tick();
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("postreset[%0d].out_valid", i), int'(bus.out_valid), 0);
    end
    add_impulse(0, 0, 0, 0);
    run_tbl("zero_coef");

    // 5-tap instance: address NC is out of range and must be ignored
    bus5.coef_we = 1'b1; bus5.coef_addr = 2'd2; bus5.coef_data = 16'sd16384;
    tick();
    bus5.coef_addr = 2'd3; bus5.coef_data = 16'sd32767; bus5.coef_commit = 1'b1;
    tick();
    bus5.coef_we = 1'b0;
    tick();
    bus5.coef_commit = 1'b0;
    bus5.in_valid = 1'b1; bus5.x_in = 8'sd10;
    for (int i = 0; i < 9; i++) tick();
    chk("taps5.out_valid", int'(bus5.out_valid), 1);
    chk("taps5.y_out", int'(bus5.y_out), 10);
    bus5.in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
